data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Responder end of the CPU data SRAM interface: accepts `data_sram_*` requests from the core, returns read data with fixed one-cycle latency, and decodes each access to either a byte-writable on-chip RAM or a small MMIO register file (LED, numeric display, switches, free-running timer). It sits in the SoC top, directly across from the core's data port, replacing a bare RAM so that tests can drive visible outputs and read time.

## Interface
Parameters:
- `RAM_AW`, 14: RAM word-address width (2^RAM_AW 32-bit words).
- `MMIO_BASE`, 16'hBFAF: value of `addr[31:16]` that selects the MMIO region.

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high reset.
- `data_sram_en` input 1: request valid this cycle.
- `data_sram_we` input 4: byte write enables; all zero means read.
- `data_sram_addr` input 32: byte address; `[1:0]` ignored.
- `data_sram_wdata` input 32: write data, byte lanes per `we`.
- `data_sram_rdata` output 32: read data for the previous cycle's request.
- `switch_in` input 8: board switch levels, sampled on MMIO read.
- `led_out` output 16: LED register.
- `num_out` output 32: numeric display register.

## Operation
- Decode: `addr[31:16]==MMIO_BASE` → MMIO; otherwise RAM at word index `addr[RAM_AW+1:2]` (upper bits aliased).
- MMIO offsets (`addr[15:0]`): 0xF000 LED (bits 15:0, RW), 0xF010 NUM (RW), 0xF020 SWITCH (bits 7:0 RO, upper bits read 0), 0xE000 TIMER (RW).
- Writes: when `en && we!=0`, each byte lane with `we[i]=1` updated; other lanes unchanged. Writes to SWITCH or unmapped MMIO offsets ignored.
- Reads: every `en` cycle (including writes) produces `rdata` in the next cycle; unmapped MMIO reads return 0.
- RAM read-during-write to same word: read-first (old data returned).
- MMIO read-during-write to same register: old value returned.
- TIMER: increments by 1 every cycle; wraps 0xFFFFFFFF → 0. A write that cycle takes precedence over increment: written lanes take `wdata`, unwritten lanes take the incremented value's lanes.

## Timing
- Read latency exactly 1 cycle; no backpressure, one request accepted per cycle.
- `rdata` holds its last value when `en` is low.
- Register writes visible on `led_out`/`num_out` the cycle after the write.
- Reset values: `data_sram_rdata`=0, `led_out`=0, `num_out`=0, TIMER=0. RAM contents not reset.
- `reset` asserted mid-operation: request in that cycle is dropped (no write, `rdata`→0); TIMER resumes from 0 the cycle after `reset` deasserts.

## Configuration
- `DATA_RESP_TIMER_EN`: defined → TIMER register present as above. Undefined → no counter logic; offset 0xE000 behaves as unmapped (reads 0, writes ignored).

## Structure
- Shared package/header `soc_map`: `MMIO_BASE` default, the four register offsets, and the reset constants.
- One sub-module `sram_bank`: parameterised-depth synchronous RAM, 4 byte write enables, registered read-first output. Decode, MMIO registers, timer, and the read mux (selected by the registered region/offset of the previous cycle) live in the top.

## Test plan
- Write 0x11223344 to 0x0000_0010 with `we`=4'hF, then write `we`=4'b0010 wdata 0xAABBCCDD, then read → `rdata`=0x1122CC44 one cycle after the read.
- Same-cycle write 0xDEADBEEF and read to address 0x20 holding 0x0 → `rdata`=0x0; following read → 0xDEADBEEF.
- Write 0x0000A5A5 to 0xBFAF_F000 → `led_out`=16'hA5A5 next cycle; write to 0xBFAF_F020 → ignored; with `switch_in`=8'h3C, read 0xBFAF_F020 → `rdata`=0x0000003C.
- Write 0xFFFFFFFE to TIMER, idle 2 cycles, read → `rdata`=0x00000000 (wrap); with macro undefined the same read → 0.
- Assert `reset` during a write to NUM → `num_out` stays 0, `rdata`=0; read 0xBFAF_1234 → 0.

Source files
------------

// File: rtl/soc_map.sv
// -----------------------------------------------------------------------------
// soc_map
// Shared SoC address-map constants for the data SRAM responder: default MMIO
// region base, MMIO register offsets, reset values, and a byte-lane merge helper.
// -----------------------------------------------------------------------------
package soc_map;

  localparam logic [15:0] MMIO_BASE_DEF = 16'hBFAF;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_SWITCH = 16'hF020;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;

  localparam logic [15:0] LED_RST   = 16'h0000;
  localparam logic [31:0] NUM_RST   = 32'h0000_0000;
  localparam logic [31:0] TIMER_RST = 32'h0000_0000;
  localparam logic [31:0] RDATA_RST = 32'h0000_0000;

  // Lanes with we[i]=1 take new_val, the rest keep old_val.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  we);
    logic [31:0] result;
    for (int i = 0; i < 4; i++)
      result[8*i +: 8] = we[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return result;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank
// Single-port synchronous RAM, 2^AW x 32 bits, four byte write enables,
// registered read-first output that holds when i_en is low.
// Ports:
//   clk      clock
//   i_en     access enable (read always, write lanes per i_we)
//   i_we     byte write enables
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data (old contents on read-during-write)
// -----------------------------------------------------------------------------
module sram_bank #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];

  // NOTE: the array has no reset so it maps onto a RAM macro; read-first
  // behaviour falls out of non-blocking assignment (the read samples the
  // array before this edge's write lands).
  always_ff @(posedge clk) begin
    if (i_en) begin
      o_rdata <= r_mem[i_addr];
      for (int i = 0; i < 4; i++)
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
// Responder for the core's data SRAM port. Decodes each request to a
// byte-writable RAM (sram_bank) or to MMIO registers (LED, NUM, SWITCH, TIMER)
// and returns read data with a fixed one-cycle latency.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   data_sram_en      request valid
//   data_sram_we      byte write enables (0 = read)
//   data_sram_addr    byte address ([1:0] ignored)
//   data_sram_wdata   write data
//   data_sram_rdata   read data for previous cycle's request (holds when idle)
//   switch_in         switch levels, sampled when SWITCH is read
//   led_out, num_out  LED and numeric display registers
// Build option: define DATA_RESP_TIMER_EN to include the free-running TIMER
// register at offset 0xE000; otherwise that offset is unmapped.
// -----------------------------------------------------------------------------
module data_sram_responder
  import soc_map::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out,
  output logic [31:0] num_out
);

  // A request arriving with reset is dropped entirely.
  logic        w_req, w_is_mmio, w_wr, w_ram_en;
  logic [15:0] w_off;
  logic        w_hit_led, w_hit_num;
  logic [31:0] w_ram_q, w_mmio_rd, w_led_merged;

  assign w_req     = data_sram_en && !reset;
  assign w_is_mmio = (data_sram_addr[31:16] == MMIO_BASE);
  assign w_off     = data_sram_addr[15:0];
  assign w_wr      = |data_sram_we;
  assign w_ram_en  = w_req && !w_is_mmio;
  assign w_hit_led = w_req && w_is_mmio && w_wr && (w_off == OFF_LED);
  assign w_hit_num = w_req && w_is_mmio && w_wr && (w_off == OFF_NUM);

  sram_bank #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (data_sram_we),
    .i_addr  (data_sram_addr[RAM_AW+1:2]),
    .i_wdata (data_sram_wdata),
    .o_rdata (w_ram_q)
  );

  logic [15:0] r_led;
  logic [31:0] r_num;

`ifdef DATA_RESP_TIMER_EN
  logic        w_hit_timer;
  logic [31:0] r_timer, w_timer_inc, w_timer_nxt;

  assign w_hit_timer = w_req && w_is_mmio && w_wr && (w_off == OFF_TIMER);
  assign w_timer_inc = r_timer + 32'd1;
  // Written lanes override; unwritten lanes still advance.
  assign w_timer_nxt = w_hit_timer ? merge_lanes(w_timer_inc, data_sram_wdata, data_sram_we)
                                   : w_timer_inc;

  always_ff @(posedge clk) begin
    if (reset) r_timer <= TIMER_RST;
    else       r_timer <= w_timer_nxt;
  end
`endif

  // MMIO read value is captured at request time, so read-during-write and
  // the switch sample both reflect the request cycle.
  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    w_mmio_rd = 32'h0;
    case (w_off)
      OFF_LED:    w_mmio_rd = {16'h0, r_led};
      OFF_NUM:    w_mmio_rd = r_num;
      OFF_SWITCH: w_mmio_rd = {24'h0, switch_in};
`ifdef DATA_RESP_TIMER_EN
      OFF_TIMER:  w_mmio_rd = r_timer;
`endif
      default:    w_mmio_rd = 32'h0;
    endcase
  end

  assign w_led_merged = merge_lanes({16'h0, r_led}, data_sram_wdata, data_sram_we);

  logic        r_sel_ram;
  logic [31:0] r_mmio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led     <= LED_RST;
      r_num     <= NUM_RST;
      r_sel_ram <= 1'b0;
      r_mmio_q  <= RDATA_RST;
    end else begin
      if (w_req) begin
        r_sel_ram <= !w_is_mmio;
        if (w_is_mmio) r_mmio_q <= w_mmio_rd;
      end
      if (w_hit_led) r_led <= w_led_merged[15:0];
      if (w_hit_num) r_num <= merge_lanes(r_num, data_sram_wdata, data_sram_we);
    end
  end

  // Selector and both sources only move on accepted requests, so the output
  // holds while idle; reset points it at the cleared MMIO capture.
  assign data_sram_rdata = r_sel_ram ? w_ram_q : r_mmio_q;
  assign led_out         = r_led;
  assign num_out         = r_num;

  logic w_unused;
  assign w_unused = ^{data_sram_addr[1:0], w_led_merged[31:16]};

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;
  import soc_map::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  logic [31:0] num_out;

  always #5 clk = ~clk;

  data_sram_responder #(.RAM_AW(14), .MMIO_BASE(16'hBFAF)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out),
    .num_out         (num_out)
  );

  typedef struct {
    logic [31:0] val;
    bit          known;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_ram[int];
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [31:0] m_last;
  bit          m_last_known;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = we[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // One clock cycle of stimulus; model predicts rdata and updates state.
  task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic rst = 1'b0);
    exp_t        e;
    bit          mmio;
    logic [15:0] off;
    int          idx;
    mmio = (addr[31:16] == 16'hBFAF);
    off  = addr[15:0];
    idx  = int'(addr[15:2]);
    e.val = 32'h0; e.known = 1'b1;
    if (!rst && en) begin
      if (mmio) begin
        case (off)
          16'hF000: e.val = {16'h0, m_led};
          16'hF010: e.val = m_num;
          16'hF020: e.val = {24'h0, switch_in};
`ifdef DATA_RESP_TIMER_EN
          16'hE000: e.val = m_timer;
`endif
          default:  e.val = 32'h0;
        endcase
      end else if (m_ram.exists(idx)) e.val = m_ram[idx];
      else e.known = 1'b0;
    end
    if (rst || en) sb_q.push_back(e);

    reset = rst; data_sram_en = en; data_sram_we = we;
    data_sram_addr = addr; data_sram_wdata = wdata;
    @(posedge clk);
    #1;

    // model state update
    if (rst) begin
      m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0;
    end else begin
      logic [31:0] t;
      t = m_timer + 32'd1;
      if (en && we != 4'h0) begin
        if (!mmio) m_ram[idx] = lanes(m_ram.exists(idx) ? m_ram[idx] : 32'h0, wdata, we);
        else if (off == 16'hF000) begin
          logic [31:0] l;
          l = lanes({16'h0, m_led}, wdata, we);
          m_led = l[15:0];
        end else if (off == 16'hF010) m_num = lanes(m_num, wdata, we);
        else if (off == 16'hE000) t = lanes(t, wdata, we);
      end
      m_timer = t;
    end

    if (rst || en) begin
      e = sb_q.pop_front();
      if (e.known) begin
        check("rdata", data_sram_rdata, e.val);
        m_last = e.val; m_last_known = 1'b1;
      end else m_last_known = 1'b0;
    end else if (m_last_known) check("rdata_hold", data_sram_rdata, m_last);
    check("led_out", {16'h0, led_out}, {16'h0, m_led});
    check("num_out", num_out, m_num);
  endtask

  initial begin
    reset = 1'b1; data_sram_en = 1'b0; data_sram_we = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0; switch_in = 8'h00;
    m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_last = 32'h0; m_last_known = 1'b0;

    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);

    // Byte-lane write on RAM
    step(1'b1, 4'hF,    32'h0000_0010, 32'h1122_3344);
    step(1'b1, 4'b0010, 32'h0000_0010, 32'hAABB_CCDD);
    step(1'b1, 4'h0,    32'h0000_0010, 32'h0);
    check("lane_merge", data_sram_rdata, 32'h1122_CC44);

    // Read-first on same-word write
    step(1'b1, 4'hF, 32'h0000_0020, 32'h0);
    step(1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF);
    check("read_first", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check("after_write", data_sram_rdata, 32'hDEAD_BEEF);

    // Upper address bits alias onto the same RAM word
    step(1'b1, 4'h0, 32'h0001_0010, 32'h0);
    check("alias", data_sram_rdata, 32'h1122_CC44);
    step(1'b0, 4'h0, 32'h0, 32'h0);

    // LED, SWITCH
    step(1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_A5A5);
    check("led_write", {16'h0, led_out}, 32'h0000_A5A5);
    step(1'b1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFF);
    switch_in = 8'h3C;
    step(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    check("switch_read", data_sram_rdata, 32'h0000_003C);
    step(1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_1234);
    check("led_rdw_old", data_sram_rdata, 32'h0000_A5A5);

    // TIMER wrap (or unmapped when the timer is not built)
    step(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    check("timer_wrap", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);

    // Reset during a NUM write
    step(1'b1, 4'hF, 32'hBFAF_F010, 32'h1234_5678, 1'b1);
    check("rst_num", num_out, 32'h0);
    check("rst_rdata", data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'hBFAF_1234, 32'h0);
    check("unmapped", data_sram_rdata, 32'h0);
    step(1'b1, 4'b0101, 32'hBFAF_F010, 32'hCAFE_F00D);
    check("num_lanes", num_out, 32'h00FE_000D);

    // Randomised mix: initialise a small RAM window, then random traffic
    for (int i = 0; i < 8; i++) step(1'b1, 4'hF, 32'h100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int          k;
      k = $urandom_range(0, 9);
      case (k)
        0: a = 32'hBFAF_F000;
        1: a = 32'hBFAF_F010;
        2: a = 32'hBFAF_F020;
        3: a = 32'hBFAF_E000;
        4: a = 32'hBFAF_0040;
        default: a = 32'h100 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      endcase
      switch_in = 8'($urandom);
      step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
